// File: rtl/pb_pkg.sv
// rtl/pb_pkg.sv - Shared types for the nested object buffer: table entry record, FSM states, end-marker id.
package pb_pkg;

  localparam int FIELD_ID_W = 16;
  localparam int OFFSET_W   = 32;

  typedef struct packed {
    logic [2:0]            wire_type;
    logic [OFFSET_W-1:0]   offset;
    logic                  nested;
    logic [FIELD_ID_W-1:0] field_id;
  } table_entry_t;

  typedef enum logic [1:0] {
    RUN,
    WAIT_DONE,
    FINISHED,
    ERROR
  } objbuf_state_e;

  localparam logic [FIELD_ID_W-1:0] END_MARKER_FIELD_ID = '0;

  function automatic logic is_end_marker(input table_entry_t e);
    return e.field_id == END_MARKER_FIELD_ID;
  endfunction

endpackage

// File: rtl/objbuf_addr_stack.sv
// rtl/objbuf_addr_stack.sv - Stack of C++ object base addresses with registered top-of-stack and depth.
module objbuf_addr_stack #(
  parameter int                 STACK_ROWS = 16,
  parameter int                 ADDR_W     = 64,
  parameter logic [ADDR_W-1:0]  ROOT_ADDR  = 'h100,
  localparam int                DW         = $clog2(STACK_ROWS)
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              push,
  input  logic [ADDR_W-1:0] push_offset,
  input  logic              pop,
  input  logic              root_load,
  input  logic [ADDR_W-1:0] root_addr,
  output logic [ADDR_W-1:0] top,
  output logic [DW-1:0]     depth,
  output logic              overflow
);

  logic [ADDR_W-1:0] mem [STACK_ROWS];
  logic [ADDR_W-1:0] child_addr;
  logic              full;

  assign full       = depth == DW'(STACK_ROWS - 1);
  assign overflow   = push && full;
  assign child_addr = top + push_offset;

  // top mirrors mem[depth] so the base stays steady across an issue/done window
  always_ff @(posedge clk) begin
    if (reset) begin
      for (int i = 0; i < STACK_ROWS; i++) begin
        mem[i] <= (i == 0) ? ROOT_ADDR : '0;
      end
      depth <= '0;
      top   <= ROOT_ADDR;
    end else if (root_load) begin
      mem[0] <= root_addr;
      depth  <= '0;
      top    <= root_addr;
    end else if (push && !full) begin
      mem[depth + DW'(1)] <= child_addr;
      depth               <= depth + DW'(1);
      top                 <= child_addr;
    end else if (pop && depth != '0) begin
      depth <= depth - DW'(1);
      top   <= mem[depth - DW'(1)];
    end
  end

endmodule

// File: rtl/nested_object_buffer.sv
// rtl/nested_object_buffer.sv - Entry FIFO plus issue FSM feeding field serializers against a nested base stack.
// Optional performance counters are built when NESTED_OBJBUF_PERF_EN is defined.
module nested_object_buffer
  import pb_pkg::*;
#(
  parameter int                ROWS       = 64,
  parameter int                STACK_ROWS = 16,
  parameter int                ADDR_W     = 64,
  parameter logic [ADDR_W-1:0] ROOT_ADDR  = 'h100,
  localparam int               PW         = $clog2(ROWS),
  localparam int               CW         = $clog2(ROWS) + 1,
  localparam int               DW         = $clog2(STACK_ROWS)
) (
  input  logic              clk,
  input  logic              reset,
  input  table_entry_t      in_entry,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [ADDR_W-1:0] root_addr,
  input  logic              root_addr_valid,
  output table_entry_t      out_entry,
  output logic              out_valid,
  input  logic              out_ready,
  input  logic              ser_done,
  output logic [ADDR_W-1:0] cpp_base_addr,
  output logic [DW-1:0]     depth,
  output logic [CW-1:0]     count,
  output logic              done,
  output logic              overflow_err,
  output logic              protocol_err
`ifdef NESTED_OBJBUF_PERF_EN
  ,
  output logic [31:0]       perf_issued,
  output logic [31:0]       perf_stall,
  output logic [DW:0]       perf_max_depth
`endif
);

  localparam logic [CW-1:0] ROWS_C = CW'(ROWS);

  table_entry_t  fifo_mem [ROWS];
  table_entry_t  head;
  logic [PW-1:0] wr_ptr;
  logic [PW-1:0] rd_ptr;
  objbuf_state_e state;

  logic fifo_wr;
  logic fifo_pop;
  logic head_em;
  logic stk_push;
  logic stk_pop;
  logic stk_ovf;
  logic root_load;

  assign head      = fifo_mem[rd_ptr];
  assign out_entry = head;
  assign head_em   = (count != '0) && is_end_marker(head);

  // no write bypass: a full FIFO refuses input even on a pop cycle
  assign in_ready  = (state != ERROR) && (count < ROWS_C);
  assign fifo_wr   = in_valid && in_ready;
  assign out_valid = (state == RUN) && (count != '0) && !head_em;

  assign fifo_pop  = ((state == RUN) && head_em) || ((state == WAIT_DONE) && ser_done);
  assign stk_pop   = (state == RUN) && head_em && (depth != '0);
  assign stk_push  = (state == WAIT_DONE) && ser_done && head.nested;
  assign root_load = root_addr_valid &&
                     (((state == RUN) && (depth == '0)) || (state == FINISHED));

  objbuf_addr_stack #(
    .STACK_ROWS (STACK_ROWS),
    .ADDR_W     (ADDR_W),
    .ROOT_ADDR  (ROOT_ADDR)
  ) u_stack (
    .clk         (clk),
    .reset       (reset),
    .push        (stk_push),
    .push_offset (ADDR_W'(head.offset)),
    .pop         (stk_pop),
    .root_load   (root_load),
    .root_addr   (root_addr),
    .top         (cpp_base_addr),
    .depth       (depth),
    .overflow    (stk_ovf)
  );

  always_ff @(posedge clk) begin
    if (fifo_wr) begin
      fifo_mem[wr_ptr] <= in_entry;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (fifo_wr)  wr_ptr <= wr_ptr + PW'(1);
      if (fifo_pop) rd_ptr <= rd_ptr + PW'(1);
      case ({fifo_wr, fifo_pop})
        2'b10:   count <= count + CW'(1);
        2'b01:   count <= count - CW'(1);
        default: count <= count;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state        <= RUN;
      done         <= 1'b0;
      overflow_err <= 1'b0;
      protocol_err <= 1'b0;
    end else begin
      if (ser_done && (state != WAIT_DONE)) protocol_err <= 1'b1;
      case (state)
        RUN: begin
          if (head_em && (depth == '0)) begin
            state <= FINISHED;
            done  <= 1'b1;
          end else if (out_valid && out_ready) begin
            state <= WAIT_DONE;
          end
        end
        WAIT_DONE: begin
          if (ser_done) begin
            if (stk_ovf) begin
              overflow_err <= 1'b1;
              state        <= ERROR;
            end else begin
              state <= RUN;
            end
          end
        end
        FINISHED: begin
          if (root_addr_valid) begin
            done  <= 1'b0;
            state <= RUN;
          end
        end
        ERROR:   state <= ERROR;
        default: state <= ERROR;
      endcase
    end
  end

`ifdef NESTED_OBJBUF_PERF_EN
  always_ff @(posedge clk) begin
    if (reset) begin
      perf_issued    <= '0;
      perf_stall     <= '0;
      perf_max_depth <= '0;
    end else begin
      if (out_valid && out_ready && (perf_issued != '1)) perf_issued <= perf_issued + 32'd1;
      if (out_valid && !out_ready && (perf_stall != '1)) perf_stall <= perf_stall + 32'd1;
      if ({1'b0, depth} > perf_max_depth) perf_max_depth <= {1'b0, depth};
    end
  end
`endif

endmodule

// File: tb/tb_nested_object_buffer.sv
// tb/tb_nested_object_buffer.sv - Directed self-checking bench for nested_object_buffer.
module tb_nested_object_buffer;
  import pb_pkg::*;

  localparam int ROWS       = 8;
  localparam int STACK_ROWS = 4;
  localparam int ADDR_W     = 64;
  localparam int DW         = $clog2(STACK_ROWS);
  localparam int CW         = $clog2(ROWS) + 1;

  logic              clk = 1'b0;
  logic              reset = 1'b1;
  table_entry_t      in_entry = '0;
  logic              in_valid = 1'b0;
  logic              in_ready;
  logic [ADDR_W-1:0] root_addr = '0;
  logic              root_addr_valid = 1'b0;
  table_entry_t      out_entry;
  logic              out_valid;
  logic              out_ready = 1'b0;
  logic              ser_done = 1'b0;
  logic [ADDR_W-1:0] cpp_base_addr;
  logic [DW-1:0]     depth;
  logic [CW-1:0]     count;
  logic              done;
  logic              overflow_err;
  logic              protocol_err;
`ifdef NESTED_OBJBUF_PERF_EN
  logic [31:0]       perf_issued;
  logic [31:0]       perf_stall;
  logic [DW:0]       perf_max_depth;
`endif

  int total = 0;
  int bad   = 0;

  always #5 clk = ~clk;

  nested_object_buffer #(
    .ROWS       (ROWS),
    .STACK_ROWS (STACK_ROWS),
    .ADDR_W     (ADDR_W)
  ) dut (
    .clk             (clk),
    .reset           (reset),
    .in_entry        (in_entry),
    .in_valid        (in_valid),
    .in_ready        (in_ready),
    .root_addr       (root_addr),
    .root_addr_valid (root_addr_valid),
    .out_entry       (out_entry),
    .out_valid       (out_valid),
    .out_ready       (out_ready),
    .ser_done        (ser_done),
    .cpp_base_addr   (cpp_base_addr),
    .depth           (depth),
    .count           (count),
    .done            (done),
    .overflow_err    (overflow_err),
    .protocol_err    (protocol_err)
`ifdef NESTED_OBJBUF_PERF_EN
    ,
    .perf_issued     (perf_issued),
    .perf_stall      (perf_stall),
    .perf_max_depth  (perf_max_depth)
`endif
  );

  function automatic table_entry_t mk(input int fid, input bit nest, input int off);
    table_entry_t e;
    e          = '0;
    e.field_id = 16'(fid);
    e.nested   = nest;
    e.offset   = 32'(off);
    return e;
  endfunction

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset;
    reset           = 1'b1;
    in_valid        = 1'b0;
    out_ready       = 1'b0;
    ser_done        = 1'b0;
    root_addr_valid = 1'b0;
    tick;
    tick;
    reset = 1'b0;
  endtask

  task automatic write_entry(input table_entry_t e);
    int n;
    n        = 0;
    in_entry = e;
    in_valid = 1'b1;
    while (!in_ready && n < 50) begin
      tick;
      n++;
    end
    total++;
    if (in_ready !== 1'b1) begin
      bad++;
      $display("FAIL write_accept: in_ready=%0b want 1", in_ready);
    end
    tick;
    in_valid = 1'b0;
  endtask

  // handshake the head, then report ser_done two cycles after issue
  task automatic issue(output logic [15:0] fid, output logic [63:0] base,
                       output logic [DW-1:0] d, output bit ok);
    int n;
    n = 0;
    while (!out_valid && n < 50) begin
      tick;
      n++;
    end
    ok   = out_valid;
    fid  = out_entry.field_id;
    base = cpp_base_addr;
    d    = depth;
    out_ready = 1'b1;
    tick;
    out_ready = 1'b0;
    tick;
    ser_done = 1'b1;
    tick;
    ser_done = 1'b0;
  endtask

  task automatic wait_done(output bit ok);
    int n;
    n = 0;
    while (!done && n < 20) begin
      tick;
      n++;
    end
    ok = done;
  endtask

  task automatic test_reset;
    do_reset;
    total++; if (count !== 0) begin bad++; $display("FAIL rst_count: got %0d want 0", count); end
    total++; if (depth !== 0) begin bad++; $display("FAIL rst_depth: got %0d want 0", depth); end
    total++; if (cpp_base_addr !== 64'h100) begin bad++; $display("FAIL rst_base: got %0h want 100", cpp_base_addr); end
    total++; if ({done, overflow_err, protocol_err, out_valid} !== 4'b0000) begin
      bad++; $display("FAIL rst_flags: got %b want 0000", {done, overflow_err, protocol_err, out_valid});
    end
    total++; if (in_ready !== 1'b1) begin bad++; $display("FAIL rst_in_ready: got %0b want 1", in_ready); end
  endtask

  task automatic test_flat;
    logic [15:0] f; logic [63:0] b; logic [DW-1:0] d; bit ok;
    do_reset;
    write_entry(mk(1, 0, 0));
    write_entry(mk(2, 0, 0));
    write_entry(mk(0, 0, 0));
    for (int i = 1; i <= 2; i++) begin
      issue(f, b, d, ok);
      total++; if (!ok || f !== 16'(i)) begin bad++; $display("FAIL flat_fid%0d: got %0d ok=%0b want %0d", i, f, ok, i); end
      total++; if (b !== 64'h100) begin bad++; $display("FAIL flat_base%0d: got %0h want 100", i, b); end
    end
    wait_done(ok);
    total++; if (!ok) begin bad++; $display("FAIL flat_done: got %0b want 1", done); end
    total++; if (count !== 0) begin bad++; $display("FAIL flat_count: got %0d want 0", count); end
  endtask

  task automatic test_nesting;
    logic [15:0] f; logic [63:0] b; logic [DW-1:0] d; bit ok;
    do_reset;
    write_entry(mk(3, 1, 'h40));
    write_entry(mk(1, 0, 0));
    write_entry(mk(0, 0, 0));
    write_entry(mk(0, 0, 0));
    issue(f, b, d, ok);
    total++; if (!ok || f !== 16'd3 || b !== 64'h100) begin
      bad++; $display("FAIL nest_parent: got fid=%0d base=%0h want fid=3 base=100", f, b);
    end
    issue(f, b, d, ok);
    total++; if (!ok || f !== 16'd1 || b !== 64'h140 || d !== 1) begin
      bad++; $display("FAIL nest_child: got fid=%0d base=%0h depth=%0d want fid=1 base=140 depth=1", f, b, d);
    end
    total++; if (out_valid !== 1'b0 || depth !== 1 || count !== 2) begin
      bad++; $display("FAIL nest_em_head: got ov=%0b depth=%0d count=%0d want 0 1 2", out_valid, depth, count);
    end
    tick;
    total++; if (depth !== 0 || cpp_base_addr !== 64'h100 || done !== 1'b0 || out_valid !== 1'b0) begin
      bad++; $display("FAIL nest_unwind: got depth=%0d base=%0h done=%0b ov=%0b want 0 100 0 0", depth, cpp_base_addr, done, out_valid);
    end
    tick;
    total++; if (done !== 1'b1 || count !== 0) begin
      bad++; $display("FAIL nest_done: got done=%0b count=%0d want 1 0", done, count);
    end
  endtask

  task automatic test_backpressure;
    logic [15:0] f; logic [63:0] b; logic [DW-1:0] d; bit ok;
    int acc;
    do_reset;
    acc = 0;
    for (int i = 1; i <= ROWS + 3; i++) begin
      in_entry = mk(i, 0, 0);
      in_valid = 1'b1;
      if (in_ready) acc++;
      tick;
    end
    in_valid = 1'b0;
    total++; if (acc !== ROWS || count !== CW'(ROWS)) begin
      bad++; $display("FAIL bp_full: got accepted=%0d count=%0d want %0d", acc, count, ROWS);
    end
    total++; if (in_ready !== 1'b0) begin bad++; $display("FAIL bp_in_ready: got %0b want 0", in_ready); end
    total++; if (out_valid !== 1'b1 || out_entry.field_id !== 16'd1) begin
      bad++; $display("FAIL bp_head: got ov=%0b fid=%0d want 1 1", out_valid, out_entry.field_id);
    end
    for (int i = 1; i <= 3; i++) begin
      issue(f, b, d, ok);
      total++; if (!ok || f !== 16'(i)) begin bad++; $display("FAIL bp_order%0d: got %0d want %0d", i, f, i); end
    end
    for (int i = ROWS + 1; i <= ROWS + 3; i++) write_entry(mk(i, 0, 0));
    for (int i = 4; i <= ROWS + 3; i++) begin
      issue(f, b, d, ok);
      total++; if (!ok || f !== 16'(i)) begin bad++; $display("FAIL bp_order%0d: got %0d want %0d", i, f, i); end
    end
    total++; if (count !== 0) begin bad++; $display("FAIL bp_drained: got %0d want 0", count); end
  endtask

  task automatic test_overflow;
    logic [15:0] f; logic [63:0] b; logic [DW-1:0] d; bit ok;
    do_reset;
    for (int i = 1; i <= STACK_ROWS; i++) write_entry(mk(i, 1, 'h10));
    for (int i = 0; i < STACK_ROWS; i++) begin
      issue(f, b, d, ok);
      total++; if (!ok || b !== 64'h100 + 64'(16 * i) || d !== DW'(i)) begin
        bad++; $display("FAIL ovf_level%0d: got base=%0h depth=%0d want %0h %0d", i, b, d, 64'h100 + 64'(16 * i), i);
      end
    end
    total++; if (overflow_err !== 1'b1 || depth !== DW'(STACK_ROWS - 1)) begin
      bad++; $display("FAIL ovf_flag: got err=%0b depth=%0d want 1 %0d", overflow_err, depth, STACK_ROWS - 1);
    end
    in_entry = mk(9, 0, 0);
    in_valid = 1'b1;
    tick; tick; tick;
    in_valid = 1'b0;
    total++; if (in_ready !== 1'b0 || out_valid !== 1'b0 || count !== 0) begin
      bad++; $display("FAIL ovf_error_state: got in_ready=%0b ov=%0b count=%0d want 0 0 0", in_ready, out_valid, count);
    end
  endtask

  task automatic test_protocol_restart;
    logic [15:0] f; logic [63:0] b; logic [DW-1:0] d; bit ok;
    do_reset;
    write_entry(mk(5, 0, 0));
    write_entry(mk(0, 0, 0));
    ser_done = 1'b1;
    tick;
    ser_done = 1'b0;
    total++; if (protocol_err !== 1'b1) begin bad++; $display("FAIL proto_flag: got %0b want 1", protocol_err); end
    total++; if (count !== 2 || out_valid !== 1'b1 || out_entry.field_id !== 16'd5) begin
      bad++; $display("FAIL proto_fifo: got count=%0d ov=%0b fid=%0d want 2 1 5", count, out_valid, out_entry.field_id);
    end
    issue(f, b, d, ok);
    wait_done(ok);
    total++; if (!ok) begin bad++; $display("FAIL restart_done: got %0b want 1", done); end
    root_addr       = 64'h2000;
    root_addr_valid = 1'b1;
    tick;
    root_addr_valid = 1'b0;
    total++; if (done !== 1'b0 || cpp_base_addr !== 64'h2000) begin
      bad++; $display("FAIL restart_root: got done=%0b base=%0h want 0 2000", done, cpp_base_addr);
    end
    write_entry(mk(7, 0, 0));
    write_entry(mk(0, 0, 0));
    issue(f, b, d, ok);
    total++; if (!ok || f !== 16'd7 || b !== 64'h2000) begin
      bad++; $display("FAIL restart_issue: got fid=%0d base=%0h want 7 2000", f, b);
    end
  endtask

  task automatic test_mid_reset;
    logic [15:0] f; logic [63:0] b; logic [DW-1:0] d; bit ok;
    int n;
    do_reset;
    write_entry(mk(1, 1, 'h40));
    write_entry(mk(2, 1, 'h40));
    write_entry(mk(3, 0, 0));
    issue(f, b, d, ok);
    issue(f, b, d, ok);
    n = 0;
    while (!out_valid && n < 50) begin tick; n++; end
    out_ready = 1'b1;
    tick;
    out_ready = 1'b0;
    total++; if (depth !== 2 || cpp_base_addr !== 64'h180 || out_valid !== 1'b0) begin
      bad++; $display("FAIL mid_pre: got depth=%0d base=%0h ov=%0b want 2 180 0", depth, cpp_base_addr, out_valid);
    end
    reset = 1'b1;
    tick;
    reset = 1'b0;
    total++; if (count !== 0 || depth !== 0 || cpp_base_addr !== 64'h100) begin
      bad++; $display("FAIL mid_reset: got count=%0d depth=%0d base=%0h want 0 0 100", count, depth, cpp_base_addr);
    end
  endtask

  initial begin
    test_reset;
    test_flat;
    test_nesting;
    test_backpressure;
    test_overflow;
    test_protocol_restart;
    test_mid_reset;
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/nested_object_buffer.md
Name: nested_object_buffer

Overview:
- Parametrised successor to the single-depth object table buffer.
- Accepts TABLE_ENTRY records from the table walker in arrival order and issues them one at a time to the field serializers using a valid/ready/done handshake.
- Keeps a stack of C++ object base addresses so that nested messages are serialized against the correct base.
- Adds the following over the previous generation: FIFO ordering, explicit input backpressure, stack-overflow and protocol error detection, and restart after completion.

Parameters:
- ROWS, 64, entry FIFO depth; must be a power of two and at least 2.
- STACK_ROWS, 16, depth of the base-address stack; must be a power of two and at least 2.
- ADDR_W, 64, width of C++ addresses.
- ROOT_ADDR, 'h100, base address of the root object after reset.

Ports:
- clk  in  1  clock.
- reset  in  1  synchronous, active-high.
- in_entry  in  TABLE_ENTRY  entry from the table walker.
- in_valid  in  1  in_entry is valid.
- in_ready  out  1  space is available; equals count < ROWS.
- root_addr  in  ADDR_W  new root base address.
- root_addr_valid  in  1  load root_addr.
- out_entry  out  TABLE_ENTRY  head entry for the serializers.
- out_valid  out  1  head entry is issuable.
- out_ready  in  1  serializers accept out_entry.
- ser_done  in  1  serializer finished the issued entry.
- cpp_base_addr  out  ADDR_W  base address for the issued entry.
- depth  out  $clog2(STACK_ROWS)  current nesting depth.
- count  out  $clog2(ROWS)+1  number of occupied FIFO rows.
- done  out  1  root end-marker reached.
- overflow_err  out  1  sticky; push attempted while the stack was full.
- protocol_err  out  1  sticky; ser_done received with no entry outstanding.

Behaviour:
- Reset values:
  - count=0, wr_ptr=rd_ptr=0, state=RUN, depth=0.
  - stack[0]=ROOT_ADDR; all other stack rows are 0.
  - cpp_base_addr=ROOT_ADDR.
  - done=0, overflow_err=0, protocol_err=0, out_valid=0.
- Reset mid-operation discards all entries and all stack contents.
- FIFO:
  - A write occurs when in_valid && in_ready; the entry goes to wr_ptr and wr_ptr increments modulo ROWS.
  - A pop increments rd_ptr modulo ROWS.
  - A write and a pop in the same cycle leave count unchanged.
  - There is no write bypass: when full, in_ready=0 even if a pop occurs in that cycle.
  - Writes are accepted in every state except ERROR.
- Head classification:
  - An entry with field_id==0 is an end-marker (EM).
  - An entry with nested==1 is a nested entry.
- States:
  - RUN:
    - If count==0: wait.
    - If the head is an EM and depth>0: consume internally (pop the entry, depth-=1) in 1 cycle; out_valid=0.
    - If the head is an EM and depth==0: pop it and go to FINISHED.
    - Otherwise: out_valid=1, and out_valid && out_ready moves to WAIT_DONE.
    - The same rules apply on every cycle, so back-to-back EMs unwind one level per cycle.
  - WAIT_DONE:
    - out_valid=0.
    - ser_done pops the head.
    - If the popped entry is nested: push stack[depth]+offset (offset zero-extended, result modulo 2^ADDR_W) and set depth+=1.
    - Then return to RUN.
    - If a push would be needed with depth==STACK_ROWS-1: set overflow_err, suppress the push, go to ERROR.
  - FINISHED:
    - done=1 (held); out_valid=0.
    - root_addr_valid sets stack[0]=root_addr and depth=0, clears done, and returns to RUN.
  - ERROR:
    - out_valid=0 and in_ready=0 until reset.
- ser_done outside WAIT_DONE: ignored, and protocol_err is set.
- Base address:
  - cpp_base_addr is registered and equals stack[depth] after every update.
  - It is therefore stable through the whole issue/done window.
  - A nested entry is serialized against its parent's base; the children that follow use the child base.
- root_addr_valid:
  - Honoured only in RUN with depth==0, or in FINISHED.
  - Updates stack[0] and cpp_base_addr on the next cycle.
  - Ignored in any other case.
- out_entry always shows the FIFO head, so it is stable while out_valid is waiting for out_ready.

Optional Feature:
- Macro name: NESTED_OBJBUF_PERF_EN.
- When defined, three extra output ports are added:
  - perf_issued (32): count of out_valid && out_ready handshakes.
  - perf_stall (32): cycles in RUN with out_valid && !out_ready.
  - perf_max_depth ($clog2(STACK_ROWS)+1): high-water mark of depth.
- All three counters saturate and are cleared by reset.
- When the macro is undefined, the ports and logic are absent; all other behaviour is identical.

Decomposition:
- Package pb_pkg:
  - TABLE_ENTRY (field_id, nested, offset, ...).
  - The objbuf_state_e enum (RUN, WAIT_DONE, FINISHED, ERROR).
  - The END_MARKER_FIELD_ID=0 constant.
- One sub-module, objbuf_addr_stack: push/pop/top, depth, and overflow detection, parametrised by STACK_ROWS and ADDR_W.
- The FIFO and the FSM stay in the top module.

Test Plan:
- Flat message:
  - Stimulus: after reset, write entries field 1 and field 2 (not nested), then an EM; out_ready=1 and ser_done 2 cycles after each issue.
  - Required response: two issues, both with cpp_base_addr=0x100; then done=1 and count=0.
- Single nesting:
  - Stimulus: write field 3 (nested, offset 0x40), field 1, EM, EM.
  - Required response: field 3 issued at 0x100; field 1 issued at 0x140 with depth=1; the first EM takes depth to 0 with no issue; the second EM sets done.
- Backpressure and full:
  - Stimulus: hold out_ready=0 and write ROWS+3 entries.
  - Required response: in_ready drops once count==ROWS; the last 3 entries stall at the source; the head is stable.
  - Then release out_ready and drain: entries come out in FIFO order, including across the rd_ptr wrap.
- Overflow:
  - Stimulus: STACK_ROWS nested entries, each completed with ser_done.
  - Required response: on the push with depth==STACK_ROWS-1, overflow_err=1, state is ERROR, and in_ready=0 and out_valid=0 until reset.
- Protocol and restart:
  - Stimulus: pulse ser_done while in RUN.
  - Required response: protocol_err=1 and FIFO state unchanged.
  - Stimulus: in FINISHED, pulse root_addr_valid with root_addr=0x2000.
  - Required response: done=0, and the next issue has cpp_base_addr=0x2000.
- Mid-run reset:
  - Stimulus: assert reset while in WAIT_DONE with depth=2.
  - Required response: on the next cycle, count=0, depth=0, and cpp_base_addr=0x100.
